// File: rtl/shift_seq_ctrl.sv
// Sequencer driving an 8-bit parallel-load shifter through load, shift and done phases.
// Optional macro SHIFT_SEQ_ABORT_EN adds abort_i to cut an operation short.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] y_i,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort_i,
`endif
    output logic [WIDTH-1:0] sh_data_o,
    output logic [1:0]       sh_S_o,
    output logic             sh_L_o,
    output logic             sh_R_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    state_t           state;
    logic [AMT_W-1:0] amt_q;
    logic [AMT_W-1:0] count;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic             abort;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // Shifter controls are registered on each transition so they line up with the state they belong to.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            amt_q     <= '0;
            count     <= '0;
            dir_q     <= 1'b0;
            mode_q    <= 2'b00;
            sh_data_o <= '0;
            sh_S_o    <= S_HOLD;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            result_o  <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sh_data_o <= opnd_i;
                        amt_q     <= amt_i;
                        dir_q     <= dir_i;
                        mode_q    <= mode_i;
                        sh_S_o    <= S_LOAD;
                        busy_o    <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    count <= amt_q;
                    if (amt_q != '0 && !abort) begin
                        sh_S_o <= dir_q ? S_LEFT : S_RIGHT;
                        state  <= SHIFT;
                    end else begin
                        sh_S_o <= S_HOLD;
                        state  <= DONE;
                    end
                end
                SHIFT: begin
                    count <= count - 1'b1;
                    if (count == AMT_W'(1) || abort) begin
                        sh_S_o <= S_HOLD;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    result_o <= y_i;
                    done_o   <= 1'b1;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    sh_S_o <= S_HOLD;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Fill bits follow the live shifter output so rotate and sign-extension see the current value.
    always_comb begin
        sh_L_o = 1'b0;
        sh_R_o = 1'b0;
        case (mode_q)
            2'b01: begin
                if (!dir_q) sh_R_o = y_i[WIDTH-1];
            end
            2'b10: begin
                if (dir_q) sh_L_o = y_i[WIDTH-1];
                else       sh_R_o = y_i[0];
            end
            default: begin
                sh_L_o = 1'b0;
                sh_R_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench pairing shift_seq_ctrl with a behavioural 8-bit parallel-load shifter.
module tb_shift_seq_ctrl;

    logic       Clk;
    logic       Rst_n;
    logic       start_i;
    logic [7:0] opnd_i;
    logic [2:0] amt_i;
    logic       dir_i;
    logic [1:0] mode_i;
    logic [7:0] y;
    logic [7:0] sh_data_o;
    logic [1:0] sh_S_o;
    logic       sh_L_o;
    logic       sh_R_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] result_o;
`ifdef SHIFT_SEQ_ABORT_EN
    logic       abort_i;
    assign abort_i = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    shift_seq_ctrl #(.WIDTH(8), .AMT_W(3)) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .start_i(start_i),
        .opnd_i(opnd_i),
        .amt_i(amt_i),
        .dir_i(dir_i),
        .mode_i(mode_i),
        .y_i(y),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort_i(abort_i),
`endif
        .sh_data_o(sh_data_o),
        .sh_S_o(sh_S_o),
        .sh_L_o(sh_L_o),
        .sh_R_o(sh_R_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .result_o(result_o)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Shifter being sequenced: hold, right with MSB fill, left with LSB fill, parallel load.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) y <= 8'h00;
        else begin
            case (sh_S_o)
                2'b01:   y <= {sh_R_o, y[7:1]};
                2'b10:   y <= {y[6:0], sh_L_o};
                2'b11:   y <= sh_data_o;
                default: y <= y;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge (end of cycle 0).
    task automatic applyStimulus(input string tag, input logic [7:0] opnd, input logic [2:0] amt,
                                 input logic dir, input logic [1:0] mode,
                                 input int inject_cyc, input logic [7:0] expected);
        int done_cyc;
        int limit;
        done_cyc = -1;
        limit    = int'(amt) + 8;
        start_i  = 1'b1;
        opnd_i   = opnd;
        amt_i    = amt;
        dir_i    = dir;
        mode_i   = mode;
        @(posedge Clk);
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge Clk);
            if (cyc == inject_cyc) begin
                start_i = 1'b1;
                opnd_i  = 8'h00;
                amt_i   = 3'd1;
                dir_i   = 1'b0;
                mode_i  = 2'b10;
            end else begin
                start_i = 1'b0;
            end
            if (cyc == 1) begin
                checkOutput({tag, " load_S"}, 32'(sh_S_o), 32'h3);
                checkOutput({tag, " load_data"}, 32'(sh_data_o), 32'(opnd));
                checkOutput({tag, " load_busy"}, 32'(busy_o), 32'h1);
            end
            if (cyc == 2)
                checkOutput({tag, " cyc2_S"}, 32'(sh_S_o),
                            (amt == 3'd0) ? 32'h0 : (dir ? 32'h2 : 32'h1));
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
        end
        start_i = 1'b0;
        checkOutput({tag, " done_cycle"}, 32'(done_cyc), 32'(int'(amt) + 3));
        checkOutput({tag, " result"}, 32'(result_o), 32'(expected));
        checkOutput({tag, " busy_after"}, 32'(busy_o), 32'h0);
        checkOutput({tag, " data_held"}, 32'(sh_data_o), 32'(opnd));
    endtask

    initial begin
        logic saw_done;
        Rst_n   = 1'b0;
        start_i = 1'b0;
        opnd_i  = 8'h00;
        amt_i   = 3'd0;
        dir_i   = 1'b0;
        mode_i  = 2'b00;

        repeat (3) @(negedge Clk);
        checkOutput("rst_S", 32'(sh_S_o), 32'h0);
        checkOutput("rst_data", 32'(sh_data_o), 32'h0);
        checkOutput("rst_L", 32'(sh_L_o), 32'h0);
        checkOutput("rst_R", 32'(sh_R_o), 32'h0);
        checkOutput("rst_busy", 32'(busy_o), 32'h0);
        checkOutput("rst_done", 32'(done_o), 32'h0);
        checkOutput("rst_result", 32'(result_o), 32'h0);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Each call starts in the done_o cycle of the previous one, so back-to-back acceptance is exercised.
        applyStimulus("log_r3", 8'hB4, 3'd3, 1'b0, 2'b00, 0, 8'h16);
        applyStimulus("ari_r2", 8'hB4, 3'd2, 1'b0, 2'b01, 0, 8'hED);
        applyStimulus("rot_l1", 8'h81, 3'd1, 1'b1, 2'b10, 0, 8'h03);
        applyStimulus("amt0", 8'h5A, 3'd0, 1'b0, 2'b00, 0, 8'h5A);
        applyStimulus("rot_r1", 8'h01, 3'd1, 1'b0, 2'b10, 0, 8'h80);
        applyStimulus("ari_l1", 8'h81, 3'd1, 1'b1, 2'b01, 0, 8'h02);
        applyStimulus("rsv_r3", 8'hB4, 3'd3, 1'b0, 2'b11, 0, 8'h16);
        applyStimulus("busy_ign", 8'hFF, 3'd7, 1'b1, 2'b00, 4, 8'h80);

        @(negedge Clk);
        start_i = 1'b1;
        opnd_i  = 8'h3C;
        amt_i   = 3'd5;
        dir_i   = 1'b1;
        mode_i  = 2'b00;
        @(negedge Clk);
        start_i = 1'b0;
        repeat (2) @(negedge Clk);
        checkOutput("mid_S_shift", 32'(sh_S_o), 32'h2);
        Rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(busy_o), 32'h0);
        checkOutput("mid_rst_S", 32'(sh_S_o), 32'h0);
        checkOutput("mid_rst_result", 32'(result_o), 32'h0);
        checkOutput("mid_rst_done", 32'(done_o), 32'h0);
        repeat (2) @(negedge Clk);
        Rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (done_o) saw_done = 1'b1;
        end
        checkOutput("no_done_after_rst", 32'(saw_done), 32'h0);
        checkOutput("idle_after_rst", 32'(busy_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer that sits directly upstream of the 8-bit shifter with parallel load.
- Accepts one operation per request: operand, shift amount, direction and mode. Drives the shifter's parallel-load, select and serial-fill inputs for the required number of cycles.
- Watches the shifter output Y_o to compute fill bits for arithmetic and rotate modes.
- Returns the final shifter value with a one-cycle done pulse.

Parameters:
- WIDTH, 8, datapath width; matches the shifter.
- AMT_W, 3, width of the shift-amount field. Maximum amount is 2^AMT_W-1.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request strobe; sampled only when busy_o=0.
- opnd_i  input  WIDTH  operand to load.
- amt_i  input  AMT_W  number of single-bit shifts.
- dir_i  input  1  0=right (toward LSB), 1=left.
- mode_i  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- y_i  input  WIDTH  shifter Y_o feedback.
- sh_data_o  output  WIDTH  to shifter data_i.
- sh_S_o  output  2  to shifter S_i: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sh_L_o  output  1  to shifter data_L (LSB fill on left shift).
- sh_R_o  output  1  to shifter data_R (MSB fill on right shift).
- busy_o  output  1  high while an operation is in progress.
- done_o  output  1  one-cycle completion pulse.
- result_o  output  WIDTH  final value; held until the next done_o.

Behaviour:
- Reset (async, Rst_n=0) values:
  - state=IDLE; sh_S_o=00; sh_data_o=0; sh_L_o=0; sh_R_o=0.
  - busy_o=0; done_o=0; result_o=0; counter=0.
- On start_i=1 in IDLE, register opnd_i, amt_i, dir_i and mode_i, then go to LOAD.
- States:
  - IDLE: sh_S_o=00, busy_o=0.
  - LOAD (1 cycle): sh_S_o=11, sh_data_o=latched operand. Next state is SHIFT if amt>0, else DONE. Counter is loaded with amt.
  - SHIFT (amt cycles): sh_S_o=01 if right, 10 if left. Counter decrements each cycle; the cycle with counter=1 is the last SHIFT, then DONE.
  - DONE (1 cycle): sh_S_o=00; y_i holds the final value. On the exit edge: result_o<=y_i, done_o<=1, state<=IDLE.
- busy_o=1 in LOAD, SHIFT and DONE.
- done_o is registered and high only in the first IDLE cycle after DONE.
- Latency: if start_i is sampled at the end of cycle 0, done_o is high in cycle amt+3.
- Fill bits are combinational from the latched mode/direction and live y_i. The inactive fill output is 0.
  - Logical: fill 0.
  - Arithmetic right: sh_R_o=y_i[WIDTH-1].
  - Arithmetic left: sh_L_o=0.
  - Rotate right: sh_R_o=y_i[0].
  - Rotate left: sh_L_o=y_i[WIDTH-1].
- Boundaries:
  - start_i while busy_o=1 is ignored; latched fields are unchanged.
  - start_i in the same cycle as done_o=1 is accepted.
  - amt=0 gives LOAD then DONE; result equals the operand.
  - Reserved mode 11 behaves as logical.
  - sh_data_o holds the latched operand outside LOAD. It is ignored by the shifter because S_i≠11.
  - Reset mid-operation returns to IDLE immediately, drives sh_S_o=00 and clears result_o; no done_o is generated.

Optional Feature:
- Macro: SHIFT_SEQ_ABORT_EN.
- When defined, an extra input abort_i (1 bit) is added.
  - abort_i=1 in LOAD or SHIFT forces DONE on the next edge.
  - The operation then completes normally, with result_o = the partially shifted value and done_o pulsing.
  - abort_i in IDLE or DONE has no effect.
- When not defined, the port and logic are absent and operations always run to completion.

Test Plan:
- Bench pairs the block with the 8-bit shifter. Reset low 3 cycles, then release.
  - Check all outputs are 0 and sh_S_o=00 during reset.
- opnd=0xB4, amt=3, right, logical -> done_o in cycle 6, result_o=0x16.
- opnd=0xB4, amt=2, right, arithmetic -> result_o=0xED.
- opnd=0x81, amt=1, left, rotate -> result_o=0x03.
- opnd=0x5A, amt=0 -> sequence LOAD, DONE; done_o in cycle 3; result_o=0x5A.
- Start 0xFF amt=7 left logical. Pulse start_i with opnd=0x00 during SHIFT -> second start ignored, result_o=0x80.
  - Then assert Rst_n=0 mid-SHIFT of a new operation -> immediate IDLE, busy_o=0, no done_o.
